// File: rtl/note_spawn_scheduler.sv
// rtl/note_spawn_scheduler.sv - beat-timed pattern scheduler issuing serialised lane spawn requests
module note_spawn_scheduler #(
  parameter int LANES       = 4,
  parameter int PATTERN_LEN = 16,
  parameter int ADDR_W      = 4,
  parameter int BEAT_CYCLES = 833333,
  parameter int TIMER_W     = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              pat_wr_en,
  input  logic [ADDR_W-1:0] pat_wr_addr,
  input  logic [LANES-1:0]  pat_wr_mask,
  output logic              map_valid,
  output logic [LANES-1:0]  map_lane,
  input  logic              map_ready,
  output logic [ADDR_W-1:0] beat_idx,
  output logic              busy,
  output logic              song_done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BEAT,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [ADDR_W-1:0]  r_beat_idx;
  logic [LANES-1:0]   r_pending;
  logic [LANES-1:0]   r_lane;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;
  logic [LANES-1:0]   r_table [PATTERN_LEN];

  logic               w_active;
  logic               w_tick;
  logic               w_last;
  logic [LANES-1:0]   w_fetched;
  logic [LANES-1:0]   w_fetch_low;
  logic [LANES-1:0]   w_pend_low;

  assign w_active    = (r_state == S_WAIT_BEAT) || (r_state == S_FETCH) || (r_state == S_ISSUE);
  assign w_tick      = w_active && !pause && (r_timer == TIMER_W'(BEAT_CYCLES - 1));
  assign w_last      = (r_beat_idx == ADDR_W'(PATTERN_LEN - 1));
  assign w_fetched   = r_table[r_beat_idx];
  // Two's-complement trick isolates the lowest set bit.
  assign w_fetch_low = w_fetched & (~w_fetched + 1'b1);
  assign w_pend_low  = r_pending & (~r_pending + 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PATTERN_LEN; i++) r_table[i] <= '0;
    end else if (pat_wr_en && (int'(pat_wr_addr) < PATTERN_LEN)) begin
      r_table[pat_wr_addr] <= pat_wr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_beat_idx <= '0;
      r_pending  <= '0;
      r_lane     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_active && !pause) r_timer <= w_tick ? '0 : r_timer + 1'b1;
      if (w_tick && (r_state != S_WAIT_BEAT)) r_overrun <= 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_WAIT_BEAT;
            r_timer    <= '0;
            r_beat_idx <= '0;
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_WAIT_BEAT: begin
          if (w_tick) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (!pause) begin
            r_pending <= w_fetched;
            if (w_fetched != '0) begin
              r_state <= S_ISSUE;
              r_valid <= 1'b1;
              r_lane  <= w_fetch_low;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_beat_idx <= r_beat_idx + 1'b1;
              r_state    <= S_WAIT_BEAT;
            end
          end
        end
        S_ISSUE: begin
          // A gap cycle follows every acceptance before the next lane is shown.
          if (!pause) begin
            if (r_valid) begin
              if (map_ready) begin
                r_pending <= r_pending & ~r_lane;
                r_valid   <= 1'b0;
              end
            end else if (r_pending != '0) begin
              r_valid <= 1'b1;
              r_lane  <= w_pend_low;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_beat_idx <= r_beat_idx + 1'b1;
              r_state    <= S_WAIT_BEAT;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign map_valid = r_valid && !pause;
  assign map_lane  = map_valid ? r_lane : '0;
  assign beat_idx  = r_beat_idx;
  assign busy      = r_busy;
  assign song_done = r_done;
  assign overrun   = r_overrun;

endmodule
